// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and instruction-fetch stage.
// Holds the architectural PC, issues one word-addressed fetch per
// instruction, presents the instruction with pc_0/pc_1 to decode and loads
// pc_next_i (branch unit result) when decode accepts the instruction.
// Loop per instruction: REQ -> WAIT (until imem_valid_i) -> HOLD (until !stall_i).
// Optional feature macro: FETCH_TIMEOUT_EN -- lost-fetch timeout in WAIT,
// sets sticky fetch_err_o and reissues the same PC.
module fetch_pc_unit #(
  parameter int              PC_W           = 64,
  parameter int              INSTR_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_next_i,
  input  logic               stall_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_valid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic [PC_W-1:0]    pc_0,
  output logic [PC_W-1:0]    pc_1,
  output logic               fetch_err_o
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;
  logic [PC_W-1:0]    r_pc_0;
  logic [PC_W-1:0]    r_pc_1;
  logic               w_capture;
  logic               w_accept;
  logic               w_tmo_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_fetch_err;

  // The counter reaches TIMEOUT_CYCLES on this silent WAIT cycle.
  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter and sticky lost-fetch flag; the counter is held at zero
  // outside WAIT so it always starts from zero on entry to WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt   <= '0;
      r_fetch_err <= 1'b0;
    end else if (r_state != S_WAIT) begin
      r_tmo_cnt <= '0;
    end else if (!imem_valid_i) begin
      if (w_tmo_hit) begin
        r_tmo_cnt   <= '0;
        r_fetch_err <= 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign fetch_err_o = r_fetch_err;
`else
  assign w_tmo_hit   = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  // Next-state decode and datapath enables. A response in WAIT takes
  // priority over a timeout in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // State, PC and the registers presented to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_pc_0        <= '0;
      r_pc_1        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr       <= imem_rdata_i;
        r_pc_0        <= r_pc;
        r_pc_1        <= r_pc + PC_W'(1);
        r_instr_valid <= 1'b1;
      end
      if (w_accept) begin
        r_pc          <= pc_next_i;
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign imem_req_o    = (r_state == S_REQ);
  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_instr_valid;
  assign pc_0          = r_pc_0;
  assign pc_1          = r_pc_1;

endmodule
